// File: rtl/lc3_exec_unit_pkg.sv
// Shared types, widths and helpers for the LC-3 execute stage.
// LC3_MUL_EN enables the iterative shift-add multiplier.
package lc3_exec_pkg;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned MUL_CYCLES = WIDTH;
    localparam int unsigned CNT_W      = $clog2(MUL_CYCLES);

    typedef logic [WIDTH-1:0] word_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_AND   = 3'b001,
        ALU_NOT   = 3'b010,
        ALU_PASSA = 3'b011,
        ALU_MUL   = 3'b100,
        ALU_SHL   = 3'b101,
        ALU_RSV6  = 3'b110,
        ALU_RSV7  = 3'b111
    } alu_op_e;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } exec_state_e;

    function automatic word_t sext5(input logic [4:0] imm);
        return {{(WIDTH-5){imm[4]}}, imm};
    endfunction

    // Exactly one of {N,Z,P} is set for any value.
    function automatic logic [2:0] nzp_of(input word_t v);
        logic neg;
        logic zero;
        neg  = v[WIDTH-1];
        zero = (v == '0);
        return {neg, zero, !neg && !zero};
    endfunction

endpackage

// File: rtl/lc3_exec_unit_if.sv
// Operand/opcode request and result/status bundle of the execute stage.
interface lc3_exec_if;
    import lc3_exec_pkg::*;

    logic        start;
    logic [2:0]  aluk;
    logic        sr2mux;
    logic [4:0]  ir_4to0;
    word_t       sr1_in;
    word_t       sr2_in;
    word_t       result;
    logic [2:0]  nzp;
    logic        busy;
    logic        done;

    modport master (
        output start, aluk, sr2mux, ir_4to0, sr1_in, sr2_in,
        input  result, nzp, busy, done
    );

    modport slave (
        input  start, aluk, sr2mux, ir_4to0, sr1_in, sr2_in,
        output result, nzp, busy, done
    );

endinterface

// File: rtl/lc3_exec_unit_shift_add_mul16.sv
// Iterative unsigned 16x16 shift-add multiplier, one partial product per step.
// o_product_c is the accumulator value after the current step.
module shift_add_mul16
    import lc3_exec_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_reset,
    input  logic  i_start,
    input  logic  i_step,
    input  word_t i_a,
    input  word_t i_b,
    output word_t o_product_c,
    output logic  o_step_done_c
);

    word_t            r_mc;
    word_t            r_mb;
    word_t            r_acc;
    logic [CNT_W-1:0] r_cnt;
    word_t            w_acc_nxt;

    assign w_acc_nxt     = r_mb[0] ? (r_acc + r_mc) : r_acc;
    assign o_product_c   = w_acc_nxt;
    assign o_step_done_c = i_step && (r_cnt == CNT_W'(MUL_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mc  <= '0;
            r_mb  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_mc  <= i_a;
            r_mb  <= i_b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_step) begin
            r_acc <= w_acc_nxt;
            r_mc  <= r_mc << 1;
            r_mb  <= r_mb >> 1;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lc3_exec_unit.sv
// LC-3 execute stage: operand select, ALU, registered Result/NZP and Done pulse.
// Define LC3_MUL_EN to add the 16-cycle iterative MUL (ALUK=100).
module lc3_exec_unit
    import lc3_exec_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    lc3_exec_if.slave  exec_if
);

    exec_state_e r_state;
    exec_state_e w_state_nxt;
    word_t       r_result;
    word_t       w_result_nxt;
    logic [2:0]  r_nzp;
    logic        r_done;
    logic        w_done_nxt;
    logic        r_busy;
    logic        w_busy_nxt;

    alu_op_e     w_op;
    word_t       w_b;
    word_t       w_alu;
    logic        w_accept;

`ifdef LC3_MUL_EN
    logic        w_mul_start;
    logic        w_mul_step;
    logic        w_mul_last;
    word_t       w_mul_prod;

    shift_add_mul16 u_mul (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_start       (w_mul_start),
        .i_step        (w_mul_step),
        .i_a           (exec_if.sr1_in),
        .i_b           (w_b),
        .o_product_c   (w_mul_prod),
        .o_step_done_c (w_mul_last)
    );
`endif

    assign w_op     = alu_op_e'(exec_if.aluk);
    assign w_b      = exec_if.sr2mux ? sext5(exec_if.ir_4to0) : exec_if.sr2_in;
    assign w_accept = exec_if.start && (r_state == IDLE);

    // Single-cycle ops; MUL (when disabled) and reserved codes pass A through.
    always_comb begin
        w_alu = exec_if.sr1_in;
        case (w_op)
            ALU_ADD: w_alu = exec_if.sr1_in + w_b;
            ALU_AND: w_alu = exec_if.sr1_in & w_b;
            ALU_NOT: w_alu = ~exec_if.sr1_in;
            ALU_SHL: w_alu = exec_if.sr1_in << w_b[3:0];
            default: w_alu = exec_if.sr1_in;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        w_done_nxt   = 1'b0;
        w_busy_nxt   = 1'b0;
`ifdef LC3_MUL_EN
        w_mul_start  = 1'b0;
        w_mul_step   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef LC3_MUL_EN
                    if (w_op == ALU_MUL) begin
                        w_state_nxt = MUL_RUN;
                        w_busy_nxt  = 1'b1;
                        w_mul_start = 1'b1;
                    end else begin
                        w_result_nxt = w_alu;
                        w_done_nxt   = 1'b1;
                    end
`else
                    w_result_nxt = w_alu;
                    w_done_nxt   = 1'b1;
`endif
                end
            end
            MUL_RUN: begin
`ifdef LC3_MUL_EN
                w_mul_step = 1'b1;
                w_busy_nxt = 1'b1;
                if (w_mul_last) begin
                    w_result_nxt = w_mul_prod;
                    w_done_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = IDLE;
                end
`else
                w_state_nxt = IDLE;
`endif
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_nzp    <= 3'b010;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
            r_nzp    <= nzp_of(w_result_nxt);
            r_done   <= w_done_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign exec_if.result = r_result;
    assign exec_if.nzp    = r_nzp;
    assign exec_if.done   = r_done;
    assign exec_if.busy   = r_busy;

endmodule

// File: tb/tb_lc3_exec_unit.sv
// Scoreboard bench for lc3_exec_unit; MUL scenarios run when LC3_MUL_EN is defined.
module tb_lc3_exec_unit;
    import lc3_exec_pkg::*;

    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  nzp;
    } exp_t;

    typedef struct packed {
        logic [2:0]  op;
        logic        mux;
        logic [4:0]  imm;
        logic [15:0] a;
        logic [15:0] b;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    lc3_exec_if ifc();

    lc3_exec_unit dut (
        .i_clk   (clk),
        .i_reset (rst),
        .exec_if (ifc)
    );

    function automatic exp_t model(input logic [2:0] op, input logic mux,
                                   input logic [4:0] imm, input logic [15:0] a,
                                   input logic [15:0] b_reg);
        logic [15:0] b;
        logic [31:0] wide;
        exp_t        e;
        b    = mux ? {{11{imm[4]}}, imm} : b_reg;
        wide = 32'(a) + 32'(b);
        case (op)
            3'd0: e.res = wide[15:0];
            3'd1: e.res = a & b;
            3'd2: e.res = ~a;
            3'd5: e.res = a << b[3:0];
`ifdef LC3_MUL_EN
            3'd4: begin
                wide  = 32'(a) * 32'(b);
                e.res = wide[15:0];
            end
`endif
            default: e.res = a;
        endcase
        if (e.res[15])          e.nzp = 3'b100;
        else if (e.res == 16'h0) e.nzp = 3'b010;
        else                     e.nzp = 3'b001;
        return e;
    endfunction

    // Drive one request for a single active edge; optionally record the expectation.
    task automatic issue(input logic [2:0] op, input logic mux, input logic [4:0] imm,
                         input logic [15:0] a, input logic [15:0] b, input bit push);
        ifc.start   = 1'b1;
        ifc.aluk    = op;
        ifc.sr2mux  = mux;
        ifc.ir_4to0 = imm;
        ifc.sr1_in  = a;
        ifc.sr2_in  = b;
        if (push) sb_q.push_back(model(op, mux, imm, a, b));
        @(posedge clk);
        #1 ifc.start = 1'b0;
    endtask

    task automatic test_reset;
        exp_t e;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (ifc.result !== 16'h0 || ifc.nzp !== 3'b010 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_init: result=%h nzp=%b busy=%b done=%b, want 0000 010 0 0",
                     ifc.result, ifc.nzp, ifc.busy, ifc.done);
        end
        rst = 1'b0;
        @(negedge clk);
        issue(3'd0, 1'b0, 5'd0, 16'h1200, 16'h0034, 1'b1);
        @(negedge clk);
        e = sb_q.pop_front();
        n_cmp++;
        if (ifc.result !== e.res || ifc.nzp !== e.nzp) begin
            n_err++;
            $display("FAIL reset_preop: result=%h nzp=%b, want %h %b", ifc.result, ifc.nzp, e.res, e.nzp);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (ifc.result !== 16'h0 || ifc.nzp !== 3'b010 || ifc.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_clear: result=%h nzp=%b done=%b, want 0000 010 0",
                     ifc.result, ifc.nzp, ifc.done);
        end
    endtask

    task automatic test_single_ops;
        vec_t vt[11];
        exp_t e;
        vt[0]  = '{3'd0, 1'b1, 5'b00001, 16'h7FFF, 16'h0000};
        vt[1]  = '{3'd1, 1'b1, 5'b10000, 16'h1234, 16'h0000};
        vt[2]  = '{3'd2, 1'b0, 5'b00000, 16'hFFFF, 16'h0000};
        vt[3]  = '{3'd3, 1'b0, 5'b00000, 16'h8001, 16'h1111};
        vt[4]  = '{3'd5, 1'b0, 5'b00000, 16'h0003, 16'h0014};
        vt[5]  = '{3'd5, 1'b0, 5'b00000, 16'h0001, 16'h000F};
        vt[6]  = '{3'd0, 1'b0, 5'b00000, 16'hFFFF, 16'h0001};
        vt[7]  = '{3'd0, 1'b1, 5'b11110, 16'h0005, 16'h0000};
        vt[8]  = '{3'd6, 1'b0, 5'b00000, 16'h0042, 16'h0007};
        vt[9]  = '{3'd7, 1'b0, 5'b00000, 16'h0000, 16'h0007};
        vt[10] = '{3'd1, 1'b0, 5'b00000, 16'hF0F0, 16'h0FF0};
        foreach (vt[i]) begin
            issue(vt[i].op, vt[i].mux, vt[i].imm, vt[i].a, vt[i].b, 1'b1);
            @(negedge clk);
            n_cmp++;
            if (ifc.done !== 1'b1 || ifc.busy !== 1'b0) begin
                n_err++;
                $display("FAIL op%0d_done: done=%b busy=%b, want 1 0", i, ifc.done, ifc.busy);
            end
            e = sb_q.pop_front();
            n_cmp++;
            if (ifc.result !== e.res || ifc.nzp !== e.nzp) begin
                n_err++;
                $display("FAIL op%0d_result: result=%h nzp=%b, want %h %b", i, ifc.result, ifc.nzp, e.res, e.nzp);
            end
            // Inputs wander with Start low: outputs must hold and Done must drop.
            ifc.sr1_in = 16'hDEAD;
            ifc.aluk   = 3'd2;
            @(negedge clk);
            n_cmp++;
            if (ifc.done !== 1'b0 || ifc.result !== e.res || ifc.nzp !== e.nzp) begin
                n_err++;
                $display("FAIL op%0d_hold: done=%b result=%h nzp=%b, want 0 %h %b",
                         i, ifc.done, ifc.result, ifc.nzp, e.res, e.nzp);
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        ifc.start = 1'b1; ifc.aluk = 3'd0; ifc.sr2mux = 1'b0;
        ifc.sr1_in = 16'h0100; ifc.sr2_in = 16'h0023;
        sb_q.push_back(model(3'd0, 1'b0, 5'd0, 16'h0100, 16'h0023));
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        n_cmp++;
        if (ifc.done !== 1'b1 || ifc.result !== e.res || ifc.nzp !== e.nzp) begin
            n_err++;
            $display("FAIL b2b_first: done=%b result=%h, want 1 %h", ifc.done, ifc.result, e.res);
        end
        ifc.aluk = 3'd2; ifc.sr1_in = 16'h00FF;
        sb_q.push_back(model(3'd2, 1'b0, 5'd0, 16'h00FF, 16'h0023));
        @(posedge clk);
        #1 ifc.start = 1'b0;
        @(negedge clk);
        e = sb_q.pop_front();
        n_cmp++;
        if (ifc.done !== 1'b1 || ifc.result !== e.res || ifc.nzp !== e.nzp) begin
            n_err++;
            $display("FAIL b2b_second: done=%b result=%h nzp=%b, want 1 %h %b",
                     ifc.done, ifc.result, ifc.nzp, e.res, e.nzp);
        end
        @(negedge clk);
    endtask

`ifdef LC3_MUL_EN
    task automatic test_mul;
        vec_t vt[3];
        exp_t e;
        vt[0] = '{3'd4, 1'b0, 5'b00000, 16'h0003, 16'h0005};
        vt[1] = '{3'd4, 1'b0, 5'b00000, 16'h0100, 16'h0100};
        vt[2] = '{3'd4, 1'b1, 5'b11111, 16'h0010, 16'h0000};
        foreach (vt[i]) begin
            issue(vt[i].op, vt[i].mux, vt[i].imm, vt[i].a, vt[i].b, 1'b1);
            for (int k = 1; k <= 17; k++) begin
                @(negedge clk);
                if (k < 17) begin
                    n_cmp++;
                    if (ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin
                        n_err++;
                        $display("FAIL mul%0d_busy_c%0d: busy=%b done=%b, want 1 0", i, k, ifc.busy, ifc.done);
                    end
                end else begin
                    e = sb_q.pop_front();
                    n_cmp++;
                    if (ifc.done !== 1'b1 || ifc.busy !== 1'b0 || ifc.result !== e.res || ifc.nzp !== e.nzp) begin
                        n_err++;
                        $display("FAIL mul%0d_result: done=%b busy=%b result=%h nzp=%b, want 1 0 %h %b",
                                 i, ifc.done, ifc.busy, ifc.result, ifc.nzp, e.res, e.nzp);
                    end
                end
            end
        end
        // Start in the Done cycle of the last MUL is accepted.
        issue(3'd0, 1'b0, 5'd0, 16'h0002, 16'h0003, 1'b1);
        @(negedge clk);
        e = sb_q.pop_front();
        n_cmp++;
        if (ifc.done !== 1'b1 || ifc.result !== e.res) begin
            n_err++;
            $display("FAIL mul_b2b: done=%b result=%h, want 1 %h", ifc.done, ifc.result, e.res);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_guard;
        exp_t e;
        int   extra;
        issue(3'd4, 1'b0, 5'd0, 16'h0007, 16'h0009, 1'b1);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 5) begin
                ifc.start = 1'b1; ifc.aluk = 3'd0; ifc.sr1_in = 16'h1111; ifc.sr2_in = 16'h2222;
            end
            if (k == 6) ifc.start = 1'b0;
            if (k < 17) begin
                n_cmp++;
                if (ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin
                    n_err++;
                    $display("FAIL guard_c%0d: busy=%b done=%b, want 1 0", k, ifc.busy, ifc.done);
                end
            end else begin
                e = sb_q.pop_front();
                n_cmp++;
                if (ifc.done !== 1'b1 || ifc.result !== e.res || ifc.nzp !== e.nzp) begin
                    n_err++;
                    $display("FAIL guard_result: done=%b result=%h nzp=%b, want 1 %h %b",
                             ifc.done, ifc.result, ifc.nzp, e.res, e.nzp);
                end
            end
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifc.done === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL guard_extra_done: pulses=%0d, want 0", extra);
        end
    endtask

    task automatic test_reset_mid_mul;
        exp_t e;
        int   pulses;
        issue(3'd4, 1'b0, 5'd0, 16'h0003, 16'h0007, 1'b0);
        for (int k = 1; k <= 8; k++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (ifc.result !== 16'h0 || ifc.nzp !== 3'b010 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_mul: result=%h nzp=%b busy=%b done=%b, want 0000 010 0 0",
                     ifc.result, ifc.nzp, ifc.busy, ifc.done);
        end
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (ifc.done === 1'b1 || ifc.busy === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL reset_abort: done/busy cycles=%0d, want 0", pulses);
        end
        issue(3'd1, 1'b0, 5'd0, 16'h00FF, 16'h0F0F, 1'b1);
        @(negedge clk);
        e = sb_q.pop_front();
        n_cmp++;
        if (ifc.done !== 1'b1 || ifc.result !== e.res) begin
            n_err++;
            $display("FAIL post_reset_op: done=%b result=%h, want 1 %h", ifc.done, ifc.result, e.res);
        end
        @(negedge clk);
    endtask
`else
    task automatic test_mul_disabled;
        exp_t e;
        int   busy_seen;
        busy_seen = 0;
        issue(3'd4, 1'b0, 5'd0, 16'h0042, 16'h0003, 1'b1);
        @(negedge clk);
        if (ifc.busy === 1'b1) busy_seen++;
        e = sb_q.pop_front();
        n_cmp++;
        if (ifc.done !== 1'b1 || ifc.result !== e.res || ifc.nzp !== e.nzp) begin
            n_err++;
            $display("FAIL mul_off: done=%b result=%h nzp=%b, want 1 %h %b",
                     ifc.done, ifc.result, ifc.nzp, e.res, e.nzp);
        end
        repeat (20) begin
            @(negedge clk);
            if (ifc.busy === 1'b1) busy_seen++;
        end
        n_cmp++;
        if (busy_seen != 0) begin
            n_err++;
            $display("FAIL mul_off_busy: busy cycles=%0d, want 0", busy_seen);
        end
    endtask
`endif

    initial begin
        ifc.start   = 1'b0;
        ifc.aluk    = 3'd0;
        ifc.sr2mux  = 1'b0;
        ifc.ir_4to0 = 5'd0;
        ifc.sr1_in  = 16'h0;
        ifc.sr2_in  = 16'h0;
        rst         = 1'b1;

        test_reset;
        test_single_ops;
        test_back_to_back;
`ifdef LC3_MUL_EN
        test_mul;
        test_busy_guard;
        test_reset_mid_mul;
`else
        test_mul_disabled;
`endif

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lc3_exec_unit.md
Name: lc3_exec_unit

Overview:
- LC-3 execute stage directly downstream of the register file.
- Consumes the SR1/SR2 read data, selects the second operand (register or sign-extended imm5), and performs the operation on a start/done handshake.
- Produces a registered 16-bit result for the register-file write-back data input, plus NZP condition codes.
- Single-cycle ops: ADD/AND/NOT/PASSA/SHL. Optional iterative 16-cycle shift-add MUL.

Parameters:
- WIDTH, 16, datapath width; fixed at 16 for LC-3; other values unsupported.
- MUL_CYCLES, 16, number of shift-add iterations; equals WIDTH.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  operation request; sampled only when Busy=0.
- ALUK  input  3  opcode: 000 ADD, 001 AND, 010 NOT, 011 PASSA, 100 MUL, 101 SHL, 110/111 reserved.
- SR2MUX  input  1  0: B=SR2_in; 1: B=sext(IR_4to0).
- IR_4to0  input  5  imm5 field.
- SR1_in  input  16  operand A, from register-file SR1 output.
- SR2_in  input  16  operand B, from register-file SR2 output.
- Result  output  16  registered result; held until the next completion.
- NZP  output  3  registered {N,Z,P} of Result.
- Busy  output  1  high while a MUL is iterating.
- Done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: sampled on a rising edge; takes priority over everything, including mid-MUL. Result=0, NZP=3'b010, Busy=0, Done=0, FSM=IDLE, counter=0, MUL aborted with no Done.
- FSM states: IDLE, MUL_RUN.
- Capture: Start=1 with Busy=0 at edge E0 latches A=SR1_in and B (after SR2MUX) into internal registers. Later changes on the input ports have no effect.
- Single-cycle ops, captured at E0:
  - Result and NZP updated at E0; Done=1 for the cycle after E0 (latency 1); FSM stays IDLE.
  - ADD: A+B mod 2^16; carry discarded, no overflow flag.
  - AND: A&B. NOT: ~A. PASSA: A.
  - SHL: A << B[3:0], zero fill.
  - Reserved opcodes: behave as PASSA.
- MUL, captured at E0:
  - FSM→MUL_RUN, counter=0, acc=0, Busy=1 from the cycle after E0.
  - Each edge E1..E16: if mb[0] then acc+=mc; mc<<=1; mb>>=1; counter++.
  - At E16: Result=low 16 bits of the final acc, NZP updated, Done=1, Busy=0, FSM→IDLE.
  - Done is high in cycle 17 after the Start cycle; high product bits are discarded; operands are treated as unsigned (low 16 bits match the two's-complement product).
- Start while Busy=1: ignored entirely; not queued.
- Back-to-back: Start in the same cycle Done=1 is accepted, since Busy=0 then.
- Done: high for exactly one cycle per accepted Start; never high while Busy=1.
- NZP: N=Result[15]; Z=(Result==0); P otherwise. Exactly one bit set at all times.
- Result and NZP change only at completion edges or Reset.

Optional Feature:
- Macro LC3_MUL_EN.
- Defined: MUL implemented as above, including the 16-cycle iterative path.
- Undefined:
  - ALUK=100 treated as reserved (PASSA, latency 1).
  - MUL_RUN state and shift-add datapath not instantiated; Busy tied to 0.

Decomposition:
- Package lc3_exec_pkg holds:
  - enum alu_op_e (ADD, AND, NOT, PASSA, MUL, SHL, RSV6, RSV7).
  - enum exec_state_e (IDLE, MUL_RUN).
  - localparam WIDTH=16.
  - sext5 function.
- One sub-module: shift_add_mul16.
  - Holds mc/mb/acc/counter; ports start, step-done.
  - Instantiated only under LC3_MUL_EN.
- The top holds the FSM, the op mux, and the Result/NZP/Done registers.

Test Plan:
- ADD: SR1_in=0x7FFF, SR2MUX=1, IR_4to0=5'b00001, Start one cycle → next cycle Result=0x8000, NZP=100, Done=1 for one cycle.
- AND imm: SR1_in=0x1234, IR_4to0=5'b10000 (B=0xFFF0) → Result=0x1230, NZP=001. NOT 0xFFFF → Result=0x0000, NZP=010.
- MUL (LC3_MUL_EN): A=3, B=5 → Busy high cycles 1–16, Done and Result=0x000F in cycle 17. A=0x0100, B=0x0100 → Result=0x0000, NZP=010.
- Busy guard: issue ADD with Start during cycle 5 of a MUL → ignored. MUL result still correct at cycle 17; no extra Done pulse.
- Reset mid-MUL: assert Reset at cycle 8 → next cycle Result=0, NZP=010, Busy=0, and Done never asserts for the aborted MUL.
- Macro off: ALUK=100, A=0x0042 → Result=0x0042 at latency 1, Busy never high.
